// File: rtl/rob_sequencer_if.sv
// Bundle of dispatch, CDB, reorder-buffer strobe, commit and store-commit
// signals. The slave side is the sequencer; the master side is its environment.
interface rob_sequencer_if #(parameter int N = 3);
  logic         disp_valid;
  logic         disp_is_store;
  logic         disp_is_branch;
  logic         disp_ready;
  logic [N-1:0] disp_tag;
  logic         cdb_valid;
  logic [N-1:0] cdb_tag;
  logic         cdb_mispredict;
  logic         rob_we;
  logic         rob_re;
  logic         rob_flush;
  logic         rob_ld_busy;
  logic         rob_busy;
  logic [N-1:0] rob_addr;
  logic         commit_valid;
  logic [N-1:0] commit_tag;
  logic         st_req;
  logic         st_ack;
  logic         flush_out;
  logic [N:0]   count;

  modport master (
    output disp_valid, disp_is_store, disp_is_branch,
    output cdb_valid, cdb_tag, cdb_mispredict,
    output st_ack,
    input  disp_ready, disp_tag,
    input  rob_we, rob_re, rob_flush, rob_ld_busy, rob_busy, rob_addr,
    input  commit_valid, commit_tag, st_req, flush_out, count
  );

  modport slave (
    input  disp_valid, disp_is_store, disp_is_branch,
    input  cdb_valid, cdb_tag, cdb_mispredict,
    input  st_ack,
    output disp_ready, disp_tag,
    output rob_we, rob_re, rob_flush, rob_ld_busy, rob_busy, rob_addr,
    output commit_valid, commit_tag, st_req, flush_out, count
  );
endinterface

// File: rtl/rob_sequencer.sv
// Reorder-buffer control sequencer: in-order allocation at dispatch, done
// marking on CDB broadcast, in-order retirement with a memory handshake for
// stores, and a single-cycle flush after a mispredicted branch retires.
module rob_sequencer #(
  parameter int N = 3
) (
  input logic           clk,
  input logic           rst_n,
  rob_sequencer_if.slave bus
);

  localparam int            DEPTH    = 1 << N;
  localparam logic [N:0]    CAPACITY = (N+1)'(DEPTH - 1);
  localparam logic [N-1:0]  PTR_ONE  = N'(1);
  localparam logic [N:0]    CNT_ONE  = (N+1)'(1);

  typedef enum logic [1:0] {
    RUN,
    ST_WAIT,
    FLUSH
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       head;
  logic [N-1:0]       tail;
  logic [N:0]         count;
  logic [DEPTH-1:0]   occ;
  logic [DEPTH-1:0]   done;
  logic [DEPTH-1:0]   is_st;
  logic [DEPTH-1:0]   is_br;
  logic [DEPTH-1:0]   mp;

  logic               disp_ready;
  logic               disp_fire;
  logic               cdb_hit;
  logic               head_ready;
  logic               commit_fire;
  logic               st_req;
  logic               flush;

  // Handshake qualification, retirement decisions and next FSM state
  always_comb begin
    state_next  = state;
    commit_fire = 1'b0;
    st_req      = 1'b0;
    flush       = 1'b0;
    head_ready  = occ[head] && done[head];
    disp_ready  = rst_n && (state != FLUSH) && (count < CAPACITY) && !bus.cdb_valid;
    disp_fire   = bus.disp_valid && disp_ready;
    cdb_hit     = bus.cdb_valid && (state != FLUSH) && occ[bus.cdb_tag];
    case (state)
      RUN: begin
        if (head_ready) begin
          if (is_st[head]) begin
            st_req     = 1'b1;
            state_next = ST_WAIT;
          end else begin
            commit_fire = 1'b1;
            if (is_br[head] && mp[head]) begin
              state_next = FLUSH;
            end
          end
        end
      end
      ST_WAIT: begin
        st_req = 1'b1;
        if (bus.st_ack) begin
          commit_fire = 1'b1;
          state_next  = RUN;
        end
      end
      FLUSH: begin
        flush      = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign bus.disp_ready   = disp_ready;
  assign bus.disp_tag     = tail;
  assign bus.rob_we       = disp_fire;
  assign bus.rob_ld_busy  = cdb_hit;
  assign bus.rob_busy     = 1'b0;
  assign bus.rob_addr     = cdb_hit ? bus.cdb_tag : '0;
  assign bus.rob_re       = commit_fire;
  assign bus.commit_valid = commit_fire;
  assign bus.commit_tag   = commit_fire ? head : '0;
  assign bus.st_req       = st_req;
  assign bus.rob_flush    = flush;
  assign bus.flush_out    = flush;
  assign bus.count        = count;

  // FSM state register; reset abandons any pending store or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, occupancy count and per-entry status bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      occ   <= '0;
      done  <= '0;
      is_st <= '0;
      is_br <= '0;
      mp    <= '0;
    end else if (state == FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      occ   <= '0;
      done  <= '0;
      is_st <= '0;
      is_br <= '0;
      mp    <= '0;
    end else begin
      if (cdb_hit) begin
        done[bus.cdb_tag] <= 1'b1;
        mp[bus.cdb_tag]   <= bus.cdb_mispredict;
      end
      if (disp_fire) begin
        occ[tail]   <= 1'b1;
        done[tail]  <= 1'b0;
        mp[tail]    <= 1'b0;
        is_st[tail] <= bus.disp_is_store;
        is_br[tail] <= bus.disp_is_branch;
        tail        <= tail + PTR_ONE;
      end
      if (commit_fire) begin
        occ[head] <= 1'b0;
        head      <= head + PTR_ONE;
      end
      case ({disp_fire, commit_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_sequencer.sv
// Self-checking bench for rob_sequencer: directed vector table, hand-written
// store / mispredict / reset sequences, and randomized traffic compared every
// cycle against a queue-based reference model of the reorder buffer.
module tb_rob_sequencer;

  localparam int N     = 3;
  localparam int DEPTH = 1 << N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rob_sequencer_if #(.N(N)) bus();

  rob_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [N-1:0] tag;
    bit           st;
    bit           br;
    bit           done;
    bit           mp;
  } ent_t;

  ent_t mq[$];
  int   m_head    = 0;
  bit   m_st_pend = 1'b0;
  bit   m_fl_pend = 1'b0;

  typedef struct {
    logic         dv, ds, db, cv;
    logic [N-1:0] ct;
    logic         cm, ack;
    logic         e_ready, e_we;
    logic [N-1:0] e_dtag;
    logic         e_ld;
    logic [N-1:0] e_addr;
    logic         e_cv;
    logic [N-1:0] e_ctag;
    logic [N:0]   e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t row(int dv, int ds, int db, int cv, int ct, int cm, int ack,
                               int rdy, int we, int dtag, int ld, int addr, int cvl,
                               int ctag, int cnt);
    vec_t r;
    r.dv      = 1'(dv);
    r.ds      = 1'(ds);
    r.db      = 1'(db);
    r.cv      = 1'(cv);
    r.ct      = N'(ct);
    r.cm      = 1'(cm);
    r.ack     = 1'(ack);
    r.e_ready = 1'(rdy);
    r.e_we    = 1'(we);
    r.e_dtag  = N'(dtag);
    r.e_ld    = 1'(ld);
    r.e_addr  = N'(addr);
    r.e_cv    = 1'(cvl);
    r.e_ctag  = N'(ctag);
    r.e_cnt   = (N+1)'(cnt);
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({bus.disp_ready, bus.rob_we, bus.disp_tag, bus.rob_ld_busy, bus.rob_addr,
                bus.rob_busy, bus.rob_re, bus.commit_valid, bus.commit_tag, bus.st_req,
                bus.rob_flush, bus.flush_out, bus.count});
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head    = 0;
    m_st_pend = 1'b0;
    m_fl_pend = 1'b0;
  endtask

  // Reference model: the ROB is a program-ordered queue of live entries
  task automatic model_check();
    logic [N-1:0] tail;
    logic [N-1:0] addr;
    logic [N-1:0] ctag;
    logic [63:0]  exp;
    bit           ready, we, hit, headok, streq, commit, flush_next;
    int           idx;
    int           size;
    ent_t         e;
    size = mq.size();
    tail = N'((m_head + size) % DEPTH);
    if (m_fl_pend) begin
      exp = 64'({1'b0, 1'b0, tail, 1'b0, N'(0), 1'b0, 1'b0, 1'b0, N'(0), 1'b0,
                 1'b1, 1'b1, (N+1)'(size)});
      check_output("model", dut_vec(), exp);
      model_reset();
    end else begin
      ready = (size < DEPTH - 1) && !bus.cdb_valid;
      we    = bus.disp_valid && ready;
      idx   = -1;
      if (bus.cdb_valid) begin
        for (int i = 0; i < size; i++) begin
          if (mq[i].tag == bus.cdb_tag) idx = i;
        end
      end
      hit        = (idx >= 0);
      addr       = hit ? bus.cdb_tag : N'(0);
      headok     = (size > 0) && mq[0].done;
      streq      = headok && mq[0].st;
      commit     = headok && (!mq[0].st || (m_st_pend && bus.st_ack));
      ctag       = commit ? mq[0].tag : N'(0);
      flush_next = commit && mq[0].br && mq[0].mp;
      exp = 64'({ready, we, tail, hit, addr, 1'b0, commit, commit, ctag, streq,
                 1'b0, 1'b0, (N+1)'(size)});
      check_output("model", dut_vec(), exp);
      if (hit) begin
        mq[idx].done = 1'b1;
        mq[idx].mp   = bus.cdb_mispredict;
      end
      if (commit) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      m_st_pend = streq && !commit;
      if (we) begin
        e.tag  = tail;
        e.st   = bus.disp_is_store;
        e.br   = bus.disp_is_branch;
        e.done = 1'b0;
        e.mp   = 1'b0;
        mq.push_back(e);
      end
      m_fl_pend = flush_next;
    end
  endtask

  task automatic apply_stimulus(input int dv, input int ds, input int db, input int cv,
                                input int ct, input int cm, input int ack);
    @(negedge clk);
    bus.disp_valid     = 1'(dv);
    bus.disp_is_store  = 1'(ds);
    bus.disp_is_branch = 1'(db);
    bus.cdb_valid      = 1'(cv);
    bus.cdb_tag        = N'(ct);
    bus.cdb_mispredict = 1'(cm);
    bus.st_ack         = 1'(ack);
    cycle++;
    #1;
    model_check();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.disp_valid     = 1'b0;
    bus.disp_is_store  = 1'b0;
    bus.disp_is_branch = 1'b0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_tag        = '0;
    bus.cdb_mispredict = 1'b0;
    bus.st_ack         = 1'b0;
    #1;
    check_output("reset_outputs", dut_vec(), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] act;
    logic [63:0] exp;
    int          dv, ds, db, cv, ct, cm, ack;

    vecs[0]  = row(1,0,0,0,0,0,0, 1,1,0,0,0,0,0,0);
    vecs[1]  = row(1,0,0,0,0,0,0, 1,1,1,0,0,0,0,1);
    vecs[2]  = row(1,0,0,0,0,0,0, 1,1,2,0,0,0,0,2);
    vecs[3]  = row(0,0,0,0,0,0,0, 1,0,3,0,0,0,0,3);
    vecs[4]  = row(1,0,0,1,1,0,0, 0,0,3,1,1,0,0,3);
    vecs[5]  = row(1,0,0,0,0,0,0, 1,1,3,0,0,0,0,3);
    vecs[6]  = row(1,0,0,0,0,0,0, 1,1,4,0,0,0,0,4);
    vecs[7]  = row(1,0,0,0,0,0,0, 1,1,5,0,0,0,0,5);
    vecs[8]  = row(1,0,0,0,0,0,0, 1,1,6,0,0,0,0,6);
    vecs[9]  = row(1,0,0,0,0,0,0, 0,0,7,0,0,0,0,7);
    vecs[10] = row(0,0,0,1,0,0,0, 0,0,7,1,0,0,0,7);
    vecs[11] = row(1,0,0,0,0,0,0, 0,0,7,0,0,1,0,7);
    vecs[12] = row(1,0,0,0,0,0,0, 1,1,7,0,0,1,1,6);
    vecs[13] = row(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,6);
    vecs[14] = row(0,0,0,1,5,0,0, 0,0,0,1,5,0,0,6);
    vecs[15] = row(0,0,0,1,0,0,0, 0,0,0,0,0,0,0,6);
    vecs[16] = row(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,6);

    $display("[TB] directed vector table");
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(int'(vecs[i].dv), int'(vecs[i].ds), int'(vecs[i].db), int'(vecs[i].cv),
                     int'(vecs[i].ct), int'(vecs[i].cm), int'(vecs[i].ack));
      act = 64'({bus.disp_ready, bus.rob_we, bus.disp_tag, bus.rob_ld_busy, bus.rob_addr,
                 bus.commit_valid, bus.commit_tag, bus.count});
      exp = 64'({vecs[i].e_ready, vecs[i].e_we, vecs[i].e_dtag, vecs[i].e_ld, vecs[i].e_addr,
                 vecs[i].e_cv, vecs[i].e_ctag, vecs[i].e_cnt});
      check_output($sformatf("vec%0d", i), act, exp);
    end

    $display("[TB] store commit with delayed acknowledge");
    reset_dut();
    apply_stimulus(1,1,0, 0,0,0,0);
    apply_stimulus(1,0,0, 0,0,0,0);
    apply_stimulus(0,0,0, 1,0,0,0);
    apply_stimulus(0,0,0, 1,1,0,0);
    check_output("st_req_raise", 64'(bus.st_req), 64'(1));
    check_output("st_no_commit", 64'(bus.commit_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0,0,0, 0,0,0,0);
      check_output("st_req_hold", 64'({bus.st_req, bus.commit_valid}), 64'(2'b10));
    end
    apply_stimulus(0,0,0, 0,0,0,1);
    check_output("st_ack_commit", 64'({bus.commit_valid, bus.rob_re, bus.commit_tag}),
                 64'({1'b1, 1'b1, N'(0)}));
    apply_stimulus(0,0,0, 0,0,0,0);
    check_output("after_store_commit", 64'({bus.commit_valid, bus.commit_tag, bus.st_req}),
                 64'({1'b1, N'(1), 1'b0}));
    apply_stimulus(0,0,0, 0,0,0,0);
    check_output("store_drained", 64'(bus.count), 64'(0));

    $display("[TB] mispredicted branch flush");
    reset_dut();
    apply_stimulus(1,0,0, 0,0,0,0);
    apply_stimulus(1,0,1, 0,0,0,0);
    apply_stimulus(1,0,0, 0,0,0,0);
    apply_stimulus(1,0,0, 0,0,0,0);
    apply_stimulus(0,0,0, 1,1,1,0);
    apply_stimulus(0,0,0, 1,0,0,0);
    apply_stimulus(0,0,0, 0,0,0,0);
    check_output("mp_commit0", 64'({bus.commit_valid, bus.commit_tag}), 64'({1'b1, N'(0)}));
    apply_stimulus(0,0,0, 0,0,0,0);
    check_output("mp_commit1", 64'({bus.commit_valid, bus.commit_tag, bus.rob_flush}),
                 64'({1'b1, N'(1), 1'b0}));
    apply_stimulus(1,0,0, 0,0,0,0);
    check_output("mp_flush", 64'({bus.rob_flush, bus.flush_out, bus.disp_ready, bus.rob_we,
                                  bus.commit_valid}), 64'(5'b11000));
    apply_stimulus(0,0,0, 0,0,0,0);
    check_output("post_flush", 64'({bus.rob_flush, bus.count, bus.disp_tag}),
                 64'({1'b0, (N+1)'(0), N'(0)}));

    $display("[TB] reset while waiting for store acknowledge");
    reset_dut();
    apply_stimulus(1,1,0, 0,0,0,0);
    apply_stimulus(0,0,0, 1,0,0,0);
    apply_stimulus(0,0,0, 0,0,0,0);
    apply_stimulus(0,0,0, 0,0,0,0);
    check_output("st_wait_entered", 64'(bus.st_req), 64'(1));
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0,0,0, 0,0,0,1);
      check_output("st_req_after_reset", 64'({bus.st_req, bus.count}), 64'(0));
    end

    $display("[TB] randomized traffic against reference model");
    for (int blk = 0; blk < 3; blk++) begin
      reset_dut();
      for (int i = 0; i < 1000; i++) begin
        dv  = ($urandom_range(0, 9) < 6) ? 1 : 0;
        ds  = ($urandom_range(0, 4) == 0) ? 1 : 0;
        db  = (ds == 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
        cv  = ($urandom_range(0, 9) < 4) ? 1 : 0;
        if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
          ct = int'(mq[$urandom_range(0, mq.size() - 1)].tag);
        end else begin
          ct = int'($urandom_range(0, DEPTH - 1));
        end
        cm  = ($urandom_range(0, 7) == 0) ? 1 : 0;
        ack = ($urandom_range(0, 2) == 0) ? 1 : 0;
        apply_stimulus(dv, ds, db, cv, ct, cm, ack);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_sequencer.md
Name: rob_sequencer

Overview:
- Control FSM that drives the reorder buffer's write, read, load-busy and flush strobes.
- Allocates entries in order at dispatch and marks entries done on CDB broadcast.
- Retires entries in order. Store commits use a memory request/acknowledge handshake.
- A mispredicted branch at the head triggers a one-cycle flush of the buffer and of the front end.

Parameters:
- N, 3: log2 of ROB depth; DEPTH = 2**N entries; usable capacity DEPTH-1, matching the buffer's full rule.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- disp_valid  in  1  dispatch request.
- disp_is_store  in  1  dispatching instruction is a store.
- disp_is_branch  in  1  dispatching instruction is a branch.
- disp_ready  out  1  entry available; a handshake occurs when disp_valid && disp_ready.
- disp_tag  out  N  ROB tag assigned, equal to the current tail.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  N  ROB tag of the result.
- cdb_mispredict  in  1  branch outcome mispredicted; meaningful only with cdb_valid.
- rob_we  out  1  buffer WE: allocate at the buffer's write pointer.
- rob_re  out  1  buffer RE: retire the head.
- rob_flush  out  1  buffer flush.
- rob_ld_busy  out  1  load busy field at rob_addr.
- rob_busy  out  1  busy value driven with rob_ld_busy; always 0.
- rob_addr  out  N  buffer addr_in for ld_* operations.
- commit_valid  out  1  head retires this cycle.
- commit_tag  out  N  tag of the retiring entry.
- st_req  out  1  store-commit request to memory.
- st_ack  in  1  memory accepted the store.
- flush_out  out  1  front-end/RS flush pulse.
- count  out  N+1  occupied entries.

Behaviour:
- Internal state:
  - head and tail pointers, N bits each, wrap mod DEPTH.
  - count register.
  - Per-entry bits occ, done, is_st, is_br, mp.
  - FSM states RUN, ST_WAIT, FLUSH.
- Reset (asynchronous, rst_n=0):
  - FSM = RUN; head = tail = count = 0; all per-entry bits = 0.
  - All outputs = 0 except disp_ready, which follows the formula below (0 while rst_n=0).
  - Reset mid-store or mid-flush abandons the operation; no st_req after release until a new store reaches the head.
- disp_ready = rst_n && (state != FLUSH) && (count < DEPTH-1) && !cdb_valid.
  - The buffer ignores ld_* while WE is high, so dispatch stalls in any cycle with a CDB broadcast.
  - disp_ready uses the registered count only: a commit in the same cycle does not free a slot until the next cycle.
- Dispatch handshake (combinational strobe, state updated on the next edge):
  - rob_we = 1 and disp_tag = tail in the same cycle.
  - At the edge: occ[tail] = 1, done = 0, mp = 0, is_st and is_br latched, tail + 1.
- CDB:
  - If cdb_valid, state != FLUSH and occ[cdb_tag]: rob_ld_busy = 1, rob_addr = cdb_tag, rob_busy = 0 in the same cycle.
  - At the edge: done[cdb_tag] = 1 and mp[cdb_tag] = cdb_mispredict.
  - A CDB to an unoccupied tag is ignored and produces no strobe.
  - done is registered, so the earliest commit is the cycle after the broadcast.
- RUN state, with head entry occupied and done:
  - Not a store: commit_valid = 1, commit_tag = head, rob_re = 1.
    - At the edge: occ[head] = 0, head + 1.
    - If is_br && mp: next state FLUSH.
  - Store: st_req = 1, no commit; next state ST_WAIT.
  - At most one commit per cycle.
- ST_WAIT state:
  - st_req held at 1 until st_ack.
  - On st_ack: commit_valid = 1, rob_re = 1, commit_tag = head, retire head; next state RUN.
  - Dispatch and CDB continue during ST_WAIT. st_ack outside ST_WAIT is ignored.
- FLUSH state (exactly one cycle):
  - rob_flush = 1, flush_out = 1; no dispatch, commit or CDB.
  - At the edge: head = tail = count = 0, all occ/done/mp cleared; next state RUN.
- count:
  - count_next = count + (dispatch fire) - (commit fire).
  - Simultaneous dispatch and commit leave count unchanged.
  - count never exceeds DEPTH-1.
- Flags: empty = (count == 0); no commit is attempted when empty.

Test Plan:
- Reset then 3 dispatches, no CDB -> disp_tag 0, 1, 2; rob_we pulses 3 cycles; count = 3; commit_valid stays 0.
- Fill with N=3: 7 dispatches -> disp_ready = 0 at count = 7; an 8th disp_valid produces no rob_we. CDB tag 0, then a commit -> disp_ready = 1 one cycle after the commit.
- CDB and disp_valid in the same cycle -> rob_ld_busy = 1, rob_addr = cdb_tag, rob_we = 0; dispatch fires next cycle with the same disp_tag.
- Store at head done -> st_req = 1; st_ack withheld 4 cycles, st_req held; on st_ack: commit_valid = 1, rob_re = 1, then the next done entry commits the following cycle.
- Branch tag 1 done with cdb_mispredict = 1, tags 2-3 occupied -> tag 0 commits, tag 1 commits, then one cycle rob_flush = flush_out = 1; afterwards count = 0 and the next disp_tag = 0.
- rst_n asserted in ST_WAIT -> all outputs 0 immediately; st_req stays 0 after release; count = 0.
